// File: rtl/seqmul_arbiter.sv
// Two-requester round-robin front end around a WIDTH x WIDTH unsigned shift-add multiplier.
// Optional build macro SEQMUL_ARB_ZERO_SKIP_EN: zero operands bypass RUN and go straight to DONE.
module seqmul_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_multiplicand,
  input  logic [WIDTH-1:0]     req0_multiplier,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_multiplicand,
  input  logic [WIDTH-1:0]     req1_multiplier,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // req*_ready depends only on state, both valids and last_grant (never rsp_ready);
  // rsp_valid/rsp_id/rsp_product are held stable until rsp_ready is seen.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, mq_q, mcand_q;
  logic [CW-1:0]     count_q;
  logic              rsp_id_q;
  logic              last_grant_q;

  logic              grant;
  logic              accept;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [WIDTH:0]    sum;
  logic              zero_op;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
  end

  assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant;
  assign sel_a      = grant ? req1_multiplicand : req0_multiplicand;
  assign sel_b      = grant ? req1_multiplier   : req0_multiplier;

`ifdef SEQMUL_ARB_ZERO_SKIP_EN
  assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // The add carry lands in sum[WIDTH] and is shifted straight into acc's MSB.
  assign sum = mq_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = zero_op ? DONE : RUN;
      RUN:  if (count_q == CW'(WIDTH - 1)) state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= '0;
      mq_q         <= '0;
      mcand_q      <= '0;
      count_q      <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mcand_q      <= sel_a;
            mq_q         <= zero_op ? '0 : sel_b;
            acc_q        <= '0;
            count_q      <= '0;
            rsp_id_q     <= grant;
            last_grant_q <= grant;
          end
        end
        RUN: begin
          acc_q   <= sum[WIDTH:1];
          mq_q    <= {sum[0], mq_q[WIDTH-1:1]};
          count_q <= count_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid   = (state_q == DONE);
  assign rsp_product = (state_q == DONE) ? {acc_q, mq_q} : '0;
  assign rsp_id      = rsp_id_q;
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seqmul_arbiter.sv
// Directed bench for seqmul_arbiter: latency, carry, round-robin, backpressure, reset, zero operands.
module tb_seqmul_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_multiplicand, req0_multiplier, req1_multiplicand, req1_multiplier;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_product;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int failed = 0;
  int cyc = 0;
  int busy_cnt = 0;
  logic rsp_valid_prev = 1'b0;

  logic [31:0] exp_q[$];
  logic        acc_id_q[$];
  int          acc_cyc_q[$];
  logic [31:0] rsp_prod_q[$];
  logic        rsp_id_q[$];
  int          rsp_cyc_q[$];
  int          rise_q[$];

`ifdef SEQMUL_ARB_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 17;
`endif

  seqmul_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_multiplicand(req0_multiplicand), .req0_multiplier(req0_multiplier),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_multiplicand(req1_multiplicand), .req1_multiplier(req1_multiplier),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Event monitor: cyc is the index of the cycle that ends at this edge.
  always @(posedge clk) begin
    if (reset) begin
      if (req0_valid && req0_ready) begin acc_id_q.push_back(1'b0); acc_cyc_q.push_back(cyc); end
      if (req1_valid && req1_ready) begin acc_id_q.push_back(1'b1); acc_cyc_q.push_back(cyc); end
      if (rsp_valid && !rsp_valid_prev) rise_q.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        rsp_prod_q.push_back(rsp_product);
        rsp_id_q.push_back(rsp_id);
        rsp_cyc_q.push_back(cyc);
      end
      if (busy) busy_cnt++;
    end
    rsp_valid_prev = reset ? rsp_valid : 1'b0;
    cyc++;
  end

  task automatic clear_logs();
    acc_id_q.delete(); acc_cyc_q.delete(); rsp_prod_q.delete();
    rsp_id_q.delete(); rsp_cyc_q.delete(); rise_q.delete(); exp_q.delete();
    busy_cnt = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    clear_logs();
  endtask

  // Driver: issue one op on port id, drop valid once accepted, wait for its response.
  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b, output bit ok);
    ok = 1'b0;
    clear_logs();
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_multiplicand = a; req1_multiplier = b; end
    else    begin req0_valid = 1'b1; req0_multiplicand = a; req0_multiplier = b; end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_cyc_q.size() > 0) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (acc_cyc_q.size() == 0) return;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (rsp_cyc_q.size() > 0) break;
    end
    ok = (rsp_cyc_q.size() > 0) && (rise_q.size() > 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_multiplicand = '0; req0_multiplier = '0; req1_multiplicand = '0; req1_multiplier = '0;
    #1;
    tests_run++;
    if ({rsp_valid, rsp_id, busy, req0_ready, req1_ready, rsp_product} !== 37'd0) begin
      failed++; $display("FAIL reset_outputs got %h exp 0", {rsp_valid, rsp_id, busy, req0_ready, req1_ready, rsp_product});
    end
    tests_run++;
    if (state_dbg !== 2'd0) begin failed++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    repeat (2) @(negedge clk);
    reset = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, rsp_valid} !== 2'b00) begin failed++; $display("FAIL reset_release got %b exp 00", {busy, rsp_valid}); end
    clear_logs();
  endtask

  task automatic test_single();
    bit ok;
    do_op(1'b0, 16'd3, 16'd5, ok);
    tests_run++;
    if (!ok) begin failed++; $display("FAIL single_timeout got no response exp response"); return; end
    tests_run++;
    if (rsp_prod_q[0] !== 32'h0000000F) begin failed++; $display("FAIL single_product got %h exp 0000000f", rsp_prod_q[0]); end
    tests_run++;
    if (rsp_id_q[0] !== 1'b0) begin failed++; $display("FAIL single_id got %b exp 0", rsp_id_q[0]); end
    tests_run++;
    if (rise_q[0] - acc_cyc_q[0] != 17) begin failed++; $display("FAIL single_latency got %0d exp 17", rise_q[0] - acc_cyc_q[0]); end
    tests_run++;
    if (rsp_cyc_q[0] - acc_cyc_q[0] != 17) begin failed++; $display("FAIL single_handshake got %0d exp 17", rsp_cyc_q[0] - acc_cyc_q[0]); end
    tests_run++;
    if (busy_cnt != 17) begin failed++; $display("FAIL single_busy_cycles got %0d exp 17", busy_cnt); end
    tests_run++;
    if (busy !== 1'b0) begin failed++; $display("FAIL single_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_carry();
    bit ok;
    do_op(1'b1, 16'hFFFF, 16'hFFFF, ok);
    tests_run++;
    if (!ok || rsp_prod_q[0] !== 32'hFFFE0001 || rsp_id_q[0] !== 1'b1) begin
      failed++; $display("FAIL carry_ffff ok %0d got %h id %b exp fffe0001 id 1", ok, ok ? rsp_prod_q[0] : 32'hx, ok ? rsp_id_q[0] : 1'bx);
    end
    do_op(1'b0, 16'h8000, 16'h0002, ok);
    tests_run++;
    if (!ok || rsp_prod_q[0] !== 32'h00010000) begin
      failed++; $display("FAIL carry_8000 ok %0d got %h exp 00010000", ok, ok ? rsp_prod_q[0] : 32'hx);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    exp_q.push_back(32'd63); exp_q.push_back(32'h00123400); exp_q.push_back(32'h00000303);
    @(negedge clk);
    req0_valid = 1'b1; req0_multiplicand = 16'd7;     req0_multiplier = 16'd9;
    req1_valid = 1'b1; req1_multiplicand = 16'h1234;  req1_multiplier = 16'h0100;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (acc_id_q.size() >= 1) begin req0_multiplicand = 16'h0101; req0_multiplier = 16'h0003; end
      if (acc_id_q.size() >= 2) req1_valid = 1'b0;
      if (acc_id_q.size() >= 3) req0_valid = 1'b0;
      if (rsp_cyc_q.size() >= 3) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests_run++;
    if (rsp_cyc_q.size() != 3 || acc_id_q.size() != 3) begin
      failed++; $display("FAIL contention_count got %0d rsp %0d acc exp 3 3", rsp_cyc_q.size(), acc_id_q.size());
      return;
    end
    tests_run++;
    if ({acc_id_q[0], acc_id_q[1], acc_id_q[2]} !== 3'b010) begin
      failed++; $display("FAIL contention_grant_order got %b exp 010", {acc_id_q[0], acc_id_q[1], acc_id_q[2]});
    end
    tests_run++;
    if ({rsp_id_q[0], rsp_id_q[1], rsp_id_q[2]} !== 3'b010) begin
      failed++; $display("FAIL contention_rsp_ids got %b exp 010", {rsp_id_q[0], rsp_id_q[1], rsp_id_q[2]});
    end
    tests_run++;
    if (acc_cyc_q[1] - acc_cyc_q[0] != 18 || acc_cyc_q[2] - acc_cyc_q[1] != 18) begin
      failed++; $display("FAIL contention_spacing got %0d %0d exp 18 18", acc_cyc_q[1] - acc_cyc_q[0], acc_cyc_q[2] - acc_cyc_q[1]);
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      tests_run++;
      if (rsp_prod_q[i] !== e) begin failed++; $display("FAIL contention_product%0d got %h exp %h", i, rsp_prod_q[i], e); end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    @(negedge clk);
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_multiplicand = 16'h00AB; req1_multiplier = 16'h0010;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (acc_id_q.size() >= 1) req1_valid = 1'b0;
      if (rise_q.size() > 0) break;
    end
    req1_valid = 1'b0;
    tests_run++;
    if (rise_q.size() == 0) begin failed++; $display("FAIL bp_timeout got no rsp_valid exp rsp_valid"); rsp_ready = 1'b1; return; end
    req0_valid = 1'b1; req0_multiplicand = 16'd5; req0_multiplier = 16'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      tests_run++;
      if ({rsp_valid, busy, req0_ready, rsp_id, rsp_product} !== {4'b1101, 32'h00000AB0}) begin
        failed++; $display("FAIL bp_hold%0d got %b%b%b%b %h exp 1101 00000ab0", k, rsp_valid, busy, req0_ready, rsp_id, rsp_product);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (acc_id_q.size() >= 2) req0_valid = 1'b0;
      if (rsp_cyc_q.size() >= 2) break;
    end
    req0_valid = 1'b0;
    tests_run++;
    if (rsp_cyc_q.size() != 2 || acc_cyc_q.size() != 2) begin
      failed++; $display("FAIL bp_drain got %0d rsp exp 2", rsp_cyc_q.size()); return;
    end
    tests_run++;
    if (rsp_cyc_q[0] != rise_q[0] + 6) begin failed++; $display("FAIL bp_handshake_cycle got %0d exp %0d", rsp_cyc_q[0], rise_q[0] + 6); end
    tests_run++;
    if (acc_cyc_q[1] != rsp_cyc_q[0] + 1) begin failed++; $display("FAIL bp_next_accept got %0d exp %0d", acc_cyc_q[1], rsp_cyc_q[0] + 1); end
    tests_run++;
    if (rsp_prod_q[0] !== 32'h00000AB0 || rsp_prod_q[1] !== 32'd30 || rsp_id_q[1] !== 1'b0) begin
      failed++; $display("FAIL bp_products got %h %h id %b exp 00000ab0 0000001e id 0", rsp_prod_q[0], rsp_prod_q[1], rsp_id_q[1]);
    end
  endtask

  task automatic test_zero();
    bit ok;
    do_op(1'b0, 16'h0000, 16'hABCD, ok);
    tests_run++;
    if (!ok) begin failed++; $display("FAIL zero_timeout got no response exp response"); return; end
    tests_run++;
    if (rsp_prod_q[0] !== 32'd0) begin failed++; $display("FAIL zero_product got %h exp 0", rsp_prod_q[0]); end
    tests_run++;
    if (rise_q[0] - acc_cyc_q[0] != ZERO_LAT) begin
      failed++; $display("FAIL zero_latency got %0d exp %0d", rise_q[0] - acc_cyc_q[0], ZERO_LAT);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_logs();
    @(negedge clk);
    req0_valid = 1'b1; req0_multiplicand = 16'd10; req0_multiplier = 16'd10;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_id_q.size() > 0) break;
    end
    req0_valid = 1'b0;
    tests_run++;
    if (acc_id_q.size() == 0) begin failed++; $display("FAIL rst_run_accept got none exp accept"); return; end
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if ({rsp_valid, busy, rsp_id, req0_ready, req1_ready, state_dbg, rsp_product} !== 39'd0) begin
      failed++; $display("FAIL rst_run_outputs got %b %b %b %0d %h exp all 0", rsp_valid, busy, rsp_id, state_dbg, rsp_product);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    repeat (25) @(negedge clk);
    tests_run++;
    if (rise_q.size() != 0) begin failed++; $display("FAIL rst_run_no_rsp got %0d rsp exp 0", rise_q.size()); end
    req0_valid = 1'b1; req0_multiplicand = 16'd2; req0_multiplier = 16'd3;
    req1_valid = 1'b1; req1_multiplicand = 16'd4; req1_multiplier = 16'd5;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (acc_id_q.size() > 0) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (rsp_cyc_q.size() > 0) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests_run++;
    if (acc_id_q.size() == 0 || rsp_cyc_q.size() == 0) begin
      failed++; $display("FAIL rst_run_regrant got no op exp op"); return;
    end
    tests_run++;
    if (acc_id_q[0] !== 1'b0 || rsp_prod_q[0] !== 32'd6) begin
      failed++; $display("FAIL rst_run_first_grant got id %b prod %h exp id 0 prod 6", acc_id_q[0], rsp_prod_q[0]);
    end
  endtask

  initial begin
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_multiplicand = '0; req0_multiplier = '0; req1_multiplicand = '0; req1_multiplier = '0;
    test_reset();
    test_single();
    test_carry();
    test_contention();
    test_backpressure();
    test_zero();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/seqmul_arbiter.md
# seqmul_arbiter

Two-requester front end for the shift-add multiplier. It arbitrates round-robin between two operand requesters and owns one WIDTH x WIDTH unsigned shift-add engine that retires one multiplier bit per cycle. It sequences LOAD/ADD/SHIFT internally, so requesters never drive add/shift/mux strobes. It returns the 2*WIDTH-bit product with the winning requester's ID on a single valid/ready response port.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH bits; iteration counter is $clog2(WIDTH)+1 bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has operands pending.
- req0_ready / req1_ready  out  1  operands accepted this cycle when ANDed with valid.
- req0_multiplicand / req1_multiplicand  in  WIDTH  unsigned operand A.
- req0_multiplier / req1_multiplier  in  WIDTH  unsigned operand B.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer takes product.
- rsp_id  out  1  0 = requester 0, 1 = requester 1.
- rsp_product  out  2*WIDTH  {acc, mq}.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, all outputs 0, acc/mq/mcand/carry/count 0, last_grant 1. With last_grant 1, requester 0 wins first.
- Reset is asynchronous. Asserting it mid-RUN or mid-DONE drops the operation with no response.
- IDLE, grant rule:
  - Only one req_valid high: grant that requester.
  - Both high: grant the requester != last_grant.
  - req_ready is combinational and high only for the granted requester, only in IDLE.
- IDLE, handshake: load mcand = A, mq = B, acc = 0, carry = 0, count = 0, rsp_id = grant, last_grant = grant; next state RUN.
- RUN, each cycle:
  - Compute sum[WIDTH:0] = mq[0] ? acc + mcand : {1'b0, acc}.
  - Update acc = sum[WIDTH:1], mq = {sum[0], mq[WIDTH-1:1]}, count++.
  - The carry lives in sum[WIDTH] and is never lost.
  - When count reaches WIDTH-1 this cycle, next state DONE.
- DONE:
  - rsp_valid = 1; rsp_product = {acc, mq} and rsp_id are held stable.
  - On rsp_valid & rsp_ready go to IDLE. No new request is accepted in that same cycle.
- Requester obligations:
  - Operands must remain stable while valid is high and ready is low.
  - Dropping valid before ready is permitted and cancels nothing, since nothing was taken.
- Product is exact: no truncation or overflow for any operands.

## Timing
- Request accepted at cycle T, RUN occupies T+1..T+WIDTH, rsp_valid rises at T+WIDTH+1. That is 17 cycles for WIDTH=16.
- With rsp_ready held high, the response handshake completes at T+WIDTH+1 and the next accept is at T+WIDTH+2. Peak throughput is one op per WIDTH+2 cycles.
- Back-to-back requests from both ports alternate strictly: 0, 1, 0, 1.
- A requester left valid is not starved for more than one operation.
- No combinational path from rsp_ready to req_ready; req_ready depends only on state, valids and last_grant.
- Simultaneous rsp handshake and new req_valid: the request waits one cycle (IDLE).

## Configuration
- SEQMUL_ARB_ZERO_SKIP_EN defined:
  - At accept, if A == 0 or B == 0, RUN is skipped and state goes straight to DONE with rsp_product = 0.
  - rsp_valid appears at T+1.
  - Arbitration and last_grant update are unchanged.
- Not defined: every operation takes the full WIDTH RUN cycles regardless of operand values.

## Test plan
- Single op: req0 3 x 5, rsp_ready = 1 -> rsp_valid at T+17, rsp_product 0x0000000F, rsp_id 0, busy high T+1..T+17.
- Carry path: req1 0xFFFF x 0xFFFF -> rsp_product 0xFFFE0001, rsp_id 1. Also 0x8000 x 0x0002 -> 0x00010000.
- Contention:
  - From reset, both valid with req0 = 7 x 9 and req1 = 0x1234 x 0x0100.
  - Required: req0 granted first (63), then req1 (0x00123400). Accepts 18 cycles apart, rsp_id sequence 0, 1.
  - A second req0 pending during req1's op is served next.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid -> product and rsp_id are stable, req_ready stays 0, busy stays 1; the handshake completes on the first cycle with rsp_ready = 1.
- Reset mid-RUN:
  - Drive reset low at T+8; all outputs 0 and state IDLE immediately, with no rsp_valid afterwards.
  - After release with both valid, req0 is granted first.
- Zero skip (macro defined): req0 0 x 0xABCD -> rsp_valid at T+1, product 0. Without the macro, the same stimulus gives rsp_valid at T+17, product 0.
